recepcao_serial_comandos: RTL and testbench

Receives elevator call requests from the host over the serial link and decodes them into queue write commands. Sits between the UART receiver (byte-valid pulse plus data byte) and the elevator request queue. Validates each 4-byte ASCII frame and pushes one (origin, destination) entry per valid frame, stalling while the queue is full. Bad frames are reported with an error pulse and a sticky code.

---
 rtl/recepcao_serial_comandos.sv | 140 ++++++++++++++
 tb/tb_recepcao_serial_comandos.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/recepcao_serial_comandos.sv
// Decodes 4-byte ASCII call frames ('#', origin, destination, '\n') from the UART
// into elevator request queue writes, reporting malformed frames with an error code.
module recepcao_serial_comandos #(
  parameter int N_ANDARES = 8,
  parameter int TIMEOUT   = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_pronto,
  input  logic [7:0] rx_dado,
  input  logic       fila_cheia,
  output logic       escreve_fila,
  output logic [2:0] origem,
  output logic [2:0] destino,
  output logic       erro_quadro,
  output logic [1:0] cod_erro,
  output logic [3:0] db_estado
);

  localparam int         CNT_W     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [7:0] CHAR_INICIO = 8'h23;
  localparam logic [7:0] CHAR_FIM    = 8'h0A;
  localparam logic [7:0] CHAR_ZERO   = 8'h30;
  localparam logic [7:0] CHAR_ULTIMO = 8'(8'h30 + N_ANDARES - 1);

  localparam logic [1:0] ERR_CHAR    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_IGUAL   = 2'b11;

  typedef enum logic [3:0] {
    ESPERA_INICIO  = 4'b0000,
    ESPERA_ORIGEM  = 4'b0001,
    ESPERA_DESTINO = 4'b0010,
    ESPERA_FIM     = 4'b0011,
    VALIDA         = 4'b0100,
    AGUARDA_FILA   = 4'b0101,
    GRAVA          = 4'b0110,
    ERRO           = 4'b1111
  } estado_t;

  estado_t          estado_q, estado_d;
  logic [2:0]       origem_q, origem_d;
  logic [2:0]       destino_q, destino_d;
  logic [1:0]       cod_erro_q, cod_erro_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic em_quadro;
  logic eh_andar;
  logic eh_inicio;
  logic expirou;

  assign em_quadro = (estado_q == ESPERA_ORIGEM) || (estado_q == ESPERA_DESTINO) ||
                     (estado_q == ESPERA_FIM);
  assign eh_andar  = (rx_dado >= CHAR_ZERO) && (rx_dado <= CHAR_ULTIMO);
  assign eh_inicio = (rx_dado == CHAR_INICIO);
  assign expirou   = (cnt_q == CNT_LIM);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q   <= ESPERA_INICIO;
      origem_q   <= 3'd0;
      destino_q  <= 3'd0;
      cod_erro_q <= 2'b00;
      cnt_q      <= '0;
    end else begin
      estado_q   <= estado_d;
      origem_q   <= origem_d;
      destino_q  <= destino_d;
      cod_erro_q <= cod_erro_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    estado_d   = estado_q;
    origem_d   = origem_q;
    destino_d  = destino_q;
    cod_erro_d = cod_erro_q;

    // Inter-byte idle counter: runs only inside a frame, saturates instead of wrapping.
    cnt_d = '0;
    if (em_quadro && !rx_pronto) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    end

    case (estado_q)
      ESPERA_INICIO: begin
        if (rx_pronto && eh_inicio) estado_d = ESPERA_ORIGEM;
      end
      ESPERA_ORIGEM, ESPERA_DESTINO, ESPERA_FIM: begin
        if (rx_pronto) begin
          if (eh_inicio) begin
            estado_d = ESPERA_ORIGEM;
          end else if (estado_q == ESPERA_ORIGEM && eh_andar) begin
            // Low 3 bits of the char equal (char - 0x30) since 0x30 is a multiple of 8.
            origem_d = rx_dado[2:0];
            estado_d = ESPERA_DESTINO;
          end else if (estado_q == ESPERA_DESTINO && eh_andar) begin
            destino_d = rx_dado[2:0];
            estado_d  = ESPERA_FIM;
          end else if (estado_q == ESPERA_FIM && rx_dado == CHAR_FIM) begin
            estado_d = VALIDA;
          end else begin
            cod_erro_d = ERR_CHAR;
            estado_d   = ERRO;
          end
        end else if (expirou) begin
          cod_erro_d = ERR_TIMEOUT;
          estado_d   = ERRO;
        end
      end
      VALIDA: begin
        if (origem_q == destino_q) begin
          cod_erro_d = ERR_IGUAL;
          estado_d   = ERRO;
        end else if (fila_cheia) begin
          estado_d = AGUARDA_FILA;
        end else begin
          estado_d = GRAVA;
        end
      end
      AGUARDA_FILA: begin
        if (!fila_cheia) estado_d = GRAVA;
      end
      GRAVA:   estado_d = ESPERA_INICIO;
      ERRO:    estado_d = ESPERA_INICIO;
      default: estado_d = ESPERA_INICIO;
    endcase
  end

  assign escreve_fila = (estado_q == GRAVA);
  assign erro_quadro  = (estado_q == ERRO);
  assign origem       = origem_q;
  assign destino      = destino_q;
  assign cod_erro     = cod_erro_q;
  assign db_estado    = estado_q;

endmodule

// File: tb/tb_recepcao_serial_comandos.sv
// Directed bench for recepcao_serial_comandos: valid frames, queue stall, char errors,
// timeout, origin==destination, resync and reset while stalled.
module tb_recepcao_serial_comandos;

  logic       clock = 1'b0;
  logic       reset;
  logic       rx_pronto;
  logic [7:0] rx_dado;
  logic       fila_cheia;
  logic       escreve_fila;
  logic [2:0] origem;
  logic [2:0] destino;
  logic       erro_quadro;
  logic [1:0] cod_erro;
  logic [3:0] db_estado;

  int checks     = 0;
  int failures   = 0;
  int wr_pulses  = 0;
  int err_pulses = 0;

  recepcao_serial_comandos #(
    .N_ANDARES(8),
    .TIMEOUT  (20)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .rx_pronto   (rx_pronto),
    .rx_dado     (rx_dado),
    .fila_cheia  (fila_cheia),
    .escreve_fila(escreve_fila),
    .origem      (origem),
    .destino     (destino),
    .erro_quadro (erro_quadro),
    .cod_erro    (cod_erro),
    .db_estado   (db_estado)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (escreve_fila === 1'b1) wr_pulses++;
    if (erro_quadro === 1'b1) err_pulses++;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clock);
    rx_pronto = 1'b1;
    rx_dado   = b;
    @(negedge clock);
    rx_pronto = 1'b0;
    rx_dado   = 8'h00;
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
    send_byte(b3);
  endtask

  // Called right after '\n' has been sampled: expects valida now, grava next cycle.
  task automatic expect_write(input string tag, input int o, input int d);
    chk({tag, "_valida"}, db_estado, 4);
    chk({tag, "_wr_early"}, escreve_fila, 0);
    @(negedge clock);
    chk({tag, "_wr"}, escreve_fila, 1);
    chk({tag, "_origem"}, origem, o);
    chk({tag, "_destino"}, destino, d);
    chk({tag, "_grava"}, db_estado, 6);
    @(negedge clock);
    chk({tag, "_wr_end"}, escreve_fila, 0);
    chk({tag, "_idle"}, db_estado, 0);
    $display("frame %s: write origem=%0d destino=%0d", tag, origem, destino);
  endtask

  initial begin
    reset      = 1'b1;
    rx_pronto  = 1'b0;
    rx_dado    = 8'h00;
    fila_cheia = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_estado", db_estado, 0);
    chk("rst_wr", escreve_fila, 0);
    chk("rst_err", erro_quadro, 0);
    chk("rst_origem", origem, 0);
    chk("rst_destino", destino, 0);
    chk("rst_cod", cod_erro, 0);
    reset = 1'b0;

    // Plain valid frame
    send_frame("#", "2", "5", 8'h0A);
    expect_write("f25", 2, 5);

    // Same frame with the queue full for 10 cycles
    fila_cheia = 1'b1;
    send_frame("#", "2", "5", 8'h0A);
    chk("stall_valida", db_estado, 4);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("stall_estado", db_estado, 5);
      chk("stall_wr", escreve_fila, 0);
    end
    fila_cheia = 1'b0;
    @(negedge clock);
    chk("stall_wr", escreve_fila, 1);
    chk("stall_origem", origem, 2);
    chk("stall_destino", destino, 5);
    @(negedge clock);
    chk("stall_wr_end", escreve_fila, 0);
    $display("frame stall25: write after fila_cheia fell, origem=%0d destino=%0d", origem, destino);

    // Out-of-range floor char
    send_byte("#");
    send_byte("9");
    chk("bad9_err", erro_quadro, 1);
    chk("bad9_cod", cod_erro, 1);
    chk("bad9_estado", db_estado, 15);
    @(negedge clock);
    chk("bad9_err_end", erro_quadro, 0);
    chk("bad9_cod_hold", cod_erro, 1);
    chk("bad9_idle", db_estado, 0);
    $display("frame bad9: error code=%0d", cod_erro);
    send_frame("#", "1", "3", 8'h0A);
    expect_write("f13", 1, 3);

    // Floor char where '\n' is expected
    send_frame("#", "5", "6", "7");
    chk("badfim_err", erro_quadro, 1);
    chk("badfim_cod", cod_erro, 1);
    $display("frame badfim: error code=%0d", cod_erro);

    // Timeout after '4' (TIMEOUT=20 -> pulse 21 cycles after the byte)
    send_byte("#");
    send_byte("4");
    repeat (19) @(negedge clock);
    chk("to_err_early", erro_quadro, 0);
    chk("to_estado_wait", db_estado, 2);
    @(negedge clock);
    chk("to_err", erro_quadro, 1);
    chk("to_cod", cod_erro, 2);
    chk("to_estado", db_estado, 15);
    @(negedge clock);
    chk("to_idle", db_estado, 0);
    $display("frame timeout: error code=%0d", cod_erro);

    // Origin equals destination
    send_frame("#", "3", "3", 8'h0A);
    chk("eq_valida", db_estado, 4);
    @(negedge clock);
    chk("eq_err", erro_quadro, 1);
    chk("eq_cod", cod_erro, 3);
    chk("eq_wr", escreve_fila, 0);
    $display("frame eq33: error code=%0d", cod_erro);

    // Resync on a second '#'
    send_byte("#");
    send_byte("1");
    send_byte("#");
    chk("resync_estado", db_estado, 1);
    chk("resync_err", erro_quadro, 0);
    send_byte("6");
    send_byte("0");
    send_byte(8'h0A);
    expect_write("resync60", 6, 0);
    chk("resync_cod_hold", cod_erro, 3);

    // Reset while stalled in aguarda_fila
    fila_cheia = 1'b1;
    send_frame("#", "7", "2", 8'h0A);
    repeat (3) @(negedge clock);
    chk("rstq_aguarda", db_estado, 5);
    reset = 1'b1;
    #1;
    chk("rstq_estado", db_estado, 0);
    chk("rstq_wr", escreve_fila, 0);
    chk("rstq_err", erro_quadro, 0);
    chk("rstq_origem", origem, 0);
    chk("rstq_destino", destino, 0);
    chk("rstq_cod", cod_erro, 0);
    @(negedge clock);
    reset      = 1'b0;
    fila_cheia = 1'b0;
    repeat (5) @(negedge clock);
    chk("rstq_idle", db_estado, 0);
    $display("frame reset72: abandoned in aguarda_fila");

    chk("total_writes", wr_pulses, 4);
    chk("total_errors", err_pulses, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
